// File: rtl/ysyx_22051145_regfile_mp_if.sv
// Bus bundle between decode (master) and the multi-port register file (slave).
// Read ports, two writeback ports, issue marking and the busy scoreboard count.
interface ysyx_22051145_regfile_mp_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;

    logic                w0_en;
    logic [AW-1:0]       w0_addr;
    logic [XLEN-1:0]     w0_data;

    logic                w1_en;
    logic [AW-1:0]       w1_addr;
    logic [XLEN-1:0]     w1_data;

    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;

    logic [AW:0]         busy_cnt;

    modport master (
        output raddr, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
               iss_en, iss_addr, flush,
        input  rdata, rbusy, busy_cnt
    );

    modport slave (
        input  raddr, w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data,
               iss_en, iss_addr, flush,
        output rdata, rbusy, busy_cnt
    );
endinterface

// File: rtl/ysyx_22051145_regfile_mp.sv
// Multi-port GPR file with same-cycle write bypass and a per-register busy
// scoreboard so decode can stall on RAW hazards. x0 reads as zero.
module ysyx_22051145_regfile_mp #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_22051145_regfile_mp_if.slave     bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] gpr [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [NREG-1:0] w0_hit;
    logic [NREG-1:0] w1_hit;
    logic [NREG-1:0] iss_hit;
    logic [AW:0]     busy_cnt_q;
    logic [AW:0]     cnt_nxt;

    // Per-register decode of the write and issue ports; index 0 never hits.
    always_comb begin
        w0_hit  = '0;
        w1_hit  = '0;
        iss_hit = '0;
        for (int r = 1; r < NREG; r++) begin
            w0_hit[r]  = bus.w0_en  && (bus.w0_addr  == AW'(r));
            w1_hit[r]  = bus.w1_en  && (bus.w1_addr  == AW'(r));
            iss_hit[r] = bus.iss_en && (bus.iss_addr == AW'(r));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                gpr[r] <= '0;
            end
        end else begin
            // port 1 (late load/CSR) wins a same-address collision
            for (int r = 1; r < NREG; r++) begin
                if (w1_hit[r]) begin
                    gpr[r] <= bus.w1_data;
                end else if (w0_hit[r]) begin
                    gpr[r] <= bus.w0_data;
                end
            end
        end
    end

    // A same-cycle issue beats a writeback clear: the new producer owns the register.
    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < NREG; r++) begin
            if (r == 0 || bus.flush) begin
                busy_nxt[r] = 1'b0;
            end else if (iss_hit[r]) begin
                busy_nxt[r] = 1'b1;
            end else if (w0_hit[r] || w1_hit[r]) begin
                busy_nxt[r] = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_cnt_q <= cnt_nxt;
        end
    end

    assign bus.busy_cnt = busy_cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit0;
        logic          hit1;

        assign ra   = bus.raddr[k*AW +: AW];
        assign hit0 = bus.w0_en && (bus.w0_addr == ra);
        assign hit1 = bus.w1_en && (bus.w1_addr == ra);

        // Outputs are forced quiet while reset is held so pending bypass data never leaks.
        assign bus.rdata[k*XLEN +: XLEN] = (!rst || ra == '0) ? '0 :
                                           hit1 ? bus.w1_data :
                                           hit0 ? bus.w0_data :
                                           gpr[ra];
        assign bus.rbusy[k] = rst && busy[ra] && !(hit0 || hit1);
    end
endmodule

// File: tb/tb_ysyx_22051145_regfile_mp.sv
// Scoreboard bench: stimulus queues expected outputs, a monitor drains and compares
// them at the falling edge (or on demand for asynchronous-reset checks).
module tb_ysyx_22051145_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_22051145_regfile_mp_if #(.XLEN(64), .NREG(32), .NRD(2)) bus_a ();
    ysyx_22051145_regfile_mp_if #(.XLEN(32), .NREG(16), .NRD(3)) bus_b ();

    ysyx_22051145_regfile_mp #(.XLEN(64), .NREG(32), .NRD(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    ysyx_22051145_regfile_mp #(.XLEN(32), .NREG(16), .NRD(3)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    typedef struct {
        int          dut;
        int          kind;
        int          port;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    event sample_now;

    // reference model for the 16x32, 3-read-port instance
    logic [31:0] m_gpr [16];
    logic [15:0] m_busy;

    function automatic logic [63:0] actual(chk_t c);
        logic [63:0] v;
        v = '0;
        if (c.dut == 0) begin
            case (c.kind)
                0:       v = bus_a.rdata[c.port*64 +: 64];
                1:       v = {63'b0, bus_a.rbusy[c.port]};
                default: v = {58'b0, bus_a.busy_cnt};
            endcase
        end else begin
            case (c.kind)
                0:       v = {32'b0, bus_b.rdata[c.port*32 +: 32]};
                1:       v = {63'b0, bus_b.rbusy[c.port]};
                default: v = {59'b0, bus_b.busy_cnt};
            endcase
        end
        return v;
    endfunction

    always @(negedge clk or sample_now) begin : mon
        chk_t        c;
        logic [63:0] a;
        while (q.size() > 0) begin
            c = q.pop_front();
            a = actual(c);
            n_chk++;
            if (a !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, a, c.exp);
            end
        end
    end

    task automatic push(int dut, int kind, int port, logic [63:0] exp, string name);
        chk_t c;
        c.dut = dut; c.kind = kind; c.port = port; c.exp = exp; c.name = name;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.w0_en = 0; bus_a.w0_addr = '0; bus_a.w0_data = '0;
        bus_a.w1_en = 0; bus_a.w1_addr = '0; bus_a.w1_data = '0;
        bus_a.iss_en = 0; bus_a.iss_addr = '0; bus_a.flush = 0;
    endtask

    task automatic idle_b();
        bus_b.w0_en = 0; bus_b.w0_addr = '0; bus_b.w0_data = '0;
        bus_b.w1_en = 0; bus_b.w1_addr = '0; bus_b.w1_data = '0;
        bus_b.iss_en = 0; bus_b.iss_addr = '0; bus_b.flush = 0;
        bus_b.raddr = '0;
    endtask

    task automatic ra(int r0, int r1);
        bus_a.raddr = {5'(r1), 5'(r0)};
    endtask

    task automatic wr0(int a, logic [63:0] d);
        bus_a.w0_en = 1; bus_a.w0_addr = 5'(a); bus_a.w0_data = d;
    endtask

    task automatic wr1(int a, logic [63:0] d);
        bus_a.w1_en = 1; bus_a.w1_addr = 5'(a); bus_a.w1_data = d;
    endtask

    task automatic iss(int a);
        bus_a.iss_en = 1; bus_a.iss_addr = 5'(a);
    endtask

    task automatic rand_cycle(int cyc);
        int          rk [3];
        logic [31:0] ed;
        logic        h0, h1;
        int          cnt;
        bus_b.w0_en    = 1'($urandom_range(0, 1));
        bus_b.w0_addr  = 4'($urandom_range(0, 15));
        bus_b.w0_data  = $urandom;
        bus_b.w1_en    = 1'($urandom_range(0, 1));
        bus_b.w1_addr  = 4'($urandom_range(0, 15));
        bus_b.w1_data  = $urandom;
        bus_b.iss_en   = 1'($urandom_range(0, 1));
        bus_b.iss_addr = 4'($urandom_range(0, 15));
        bus_b.flush    = ($urandom_range(0, 31) == 0);
        for (int k = 0; k < 3; k++) rk[k] = $urandom_range(0, 15);
        bus_b.raddr = {4'(rk[2]), 4'(rk[1]), 4'(rk[0])};

        cnt = 0;
        for (int r = 0; r < 16; r++) cnt += int'(m_busy[r]);
        for (int k = 0; k < 3; k++) begin
            h0 = bus_b.w0_en && (int'(bus_b.w0_addr) == rk[k]);
            h1 = bus_b.w1_en && (int'(bus_b.w1_addr) == rk[k]);
            if (rk[k] == 0)  ed = '0;
            else if (h1)     ed = bus_b.w1_data;
            else if (h0)     ed = bus_b.w0_data;
            else             ed = m_gpr[rk[k]];
            push(1, 0, k, {32'b0, ed}, $sformatf("rnd_rdata%0d_c%0d", k, cyc));
            push(1, 1, k, {63'b0, m_busy[rk[k]] && !(h0 || h1)},
                 $sformatf("rnd_rbusy%0d_c%0d", k, cyc));
        end
        push(1, 2, 0, 64'(cnt), $sformatf("rnd_cnt_c%0d", cyc));

        for (int r = 1; r < 16; r++) begin
            h0 = bus_b.w0_en && (int'(bus_b.w0_addr) == r);
            h1 = bus_b.w1_en && (int'(bus_b.w1_addr) == r);
            if (h1)      m_gpr[r] = bus_b.w1_data;
            else if (h0) m_gpr[r] = bus_b.w0_data;
            if (bus_b.flush)                                         m_busy[r] = 1'b0;
            else if (bus_b.iss_en && int'(bus_b.iss_addr) == r)      m_busy[r] = 1'b1;
            else if (h0 || h1)                                       m_busy[r] = 1'b0;
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) m_gpr[r] = '0;
        m_busy = '0;
        idle_a();
        idle_b();
        ra(5, 7);
        push(0, 0, 0, 64'h0, "rst_init_rdata");
        push(0, 1, 1, 64'h0, "rst_init_rbusy");
        push(0, 2, 0, 64'h0, "rst_init_cnt");
        tick();
        rst = 1'b1;

        // reset: build up state, then drop reset mid-cycle with writes pending
        tick(); wr0(5, 64'h1234); iss(7); ra(5, 7);
        push(0, 0, 0, 64'h1234, "rst_bypass_x5");
        push(0, 1, 1, 64'h0,    "rst_iss_same_cycle");
        tick(); idle_a();
        push(0, 0, 0, 64'h1234, "rst_stored_x5");
        push(0, 1, 1, 64'h1,    "rst_busy_x7");
        push(0, 2, 0, 64'h1,    "rst_cnt_one");
        @(negedge clk); #1;
        wr0(5, 64'h9999); iss(9);
        rst = 1'b0;
        #1;
        push(0, 0, 0, 64'h0, "rst_async_rdata");
        push(0, 1, 1, 64'h0, "rst_async_rbusy");
        push(0, 2, 0, 64'h0, "rst_async_cnt");
        -> sample_now;
        tick(); idle_a(); rst = 1'b1;
        push(0, 0, 0, 64'h0, "rst_after_x5");
        push(0, 1, 1, 64'h0, "rst_after_x7");
        push(0, 2, 0, 64'h0, "rst_after_cnt");

        // bypass on both ports, then x0
        tick(); wr0(3, 64'hAAAA); wr1(4, 64'hBBBB); ra(3, 4);
        push(0, 0, 0, 64'hAAAA, "byp_w0");
        push(0, 0, 1, 64'hBBBB, "byp_w1");
        tick(); idle_a();
        push(0, 0, 0, 64'hAAAA, "stor_x3");
        push(0, 0, 1, 64'hBBBB, "stor_x4");
        tick(); wr0(0, 64'hFFFF); ra(0, 3);
        push(0, 0, 0, 64'h0, "x0_same_cycle");
        tick(); idle_a();
        push(0, 0, 0, 64'h0, "x0_next_cycle");

        // collision: port 1 wins
        tick(); wr0(9, 64'h1111); wr1(9, 64'h2222); ra(9, 3);
        push(0, 0, 0, 64'h2222, "coll_bypass");
        tick(); idle_a();
        push(0, 0, 0, 64'h2222, "coll_stored");

        // scoreboard set and writeback clear
        tick(); iss(10); ra(10, 0);
        push(0, 1, 0, 64'h0, "sb_iss_same_cycle");
        push(0, 2, 0, 64'h0, "sb_cnt_before");
        tick(); idle_a();
        push(0, 1, 0, 64'h1, "sb_busy_x10");
        push(0, 2, 0, 64'h1, "sb_cnt_one");
        tick(); wr1(10, 64'h55);
        push(0, 1, 0, 64'h0,  "sb_wr_clear_bypass");
        push(0, 0, 0, 64'h55, "sb_wr_data");
        push(0, 2, 0, 64'h1,  "sb_cnt_pre_edge");
        tick(); idle_a();
        push(0, 2, 0, 64'h0,  "sb_cnt_zero");
        push(0, 0, 0, 64'h55, "sb_data_stored");

        // issue beats same-cycle write; flush beats issue
        tick(); iss(12); wr0(12, 64'h77); ra(12, 13);
        push(0, 0, 0, 64'h77, "iw_bypass");
        push(0, 1, 0, 64'h0,  "iw_rbusy_masked");
        tick(); idle_a();
        push(0, 1, 0, 64'h1,  "iw_busy_x12");
        push(0, 0, 0, 64'h77, "iw_stored");
        push(0, 2, 0, 64'h1,  "iw_cnt");
        tick(); iss(13); bus_a.flush = 1;
        push(0, 1, 0, 64'h1,  "fl_busy_pre");
        tick(); idle_a();
        push(0, 1, 0, 64'h0,  "fl_x12_clear");
        push(0, 1, 1, 64'h0,  "fl_x13_not_set");
        push(0, 2, 0, 64'h0,  "fl_cnt");

        // count across several busy registers, clears on both ports at once
        tick(); iss(1);
        tick(); iss(2);
        tick(); iss(31); ra(2, 31);
        push(0, 2, 0, 64'h2, "cnt_two");
        tick(); idle_a();
        push(0, 2, 0, 64'h3, "cnt_three");
        push(0, 1, 1, 64'h1, "cnt_busy_x31");
        tick(); wr0(2, 64'h1); wr1(31, 64'h2); iss(0);
        push(0, 1, 0, 64'h0, "cnt_clr_byp0");
        push(0, 1, 1, 64'h0, "cnt_clr_byp1");
        tick(); idle_a();
        push(0, 2, 0, 64'h1, "cnt_one_left");

        // randomised run on the 16x32 / 3-port instance
        for (int c = 0; c < 10000; c++) begin
            tick();
            rand_cycle(c);
        end
        tick(); idle_b();
        tick();
        tick();
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22051145_regfile_mp.md
# ysyx_22051145_regfile_mp

Parametrised multi-port general-purpose register file with write bypass and a per-register busy scoreboard. It sits in the NPC decode stage. It serves NRD read ports and two write ports: port 0 for ALU writeback and port 1 for late load/CSR writeback. Register 0 is hard-wired to zero. The scoreboard tracks destinations of issued-but-not-written instructions so decode can stall on RAW hazards.

## Interface
- XLEN, 64, data width of each register
- NREG, 32, number of architectural registers (power of two, ≥2)
- NRD, 2, number of read ports
- AW, $clog2(NREG), address width (derived, not overridden)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- raddr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- rdata  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- rbusy  out  NRD  port k register has a pending producer
- w0_en / w0_addr / w0_data  in  1 / AW / XLEN  write port 0
- w1_en / w1_addr / w1_data  in  1 / AW / XLEN  write port 1
- iss_en / iss_addr  in  1 / AW  mark register busy (instruction issued with destination)
- flush  in  1  synchronous clear of all busy bits
- busy_cnt  out  AW+1  number of registers currently busy

## Operation
- Storage: NREG×XLEN array plus NREG busy bits. Entry 0 is never written. busy[0] is constant 0.
- Write: on the rising edge with wX_en=1 and wX_addr≠0, gpr[wX_addr] ← wX_data.
  - Both ports target the same nonzero address: port 1 data is stored, port 0 is dropped.
  - Writes to address 0 are ignored.
- Read (combinational): rdata[k] is computed with this priority:
  1. raddr[k]=0 → 0
  2. w1_en and w1_addr=raddr[k] → w1_data
  3. w0_en and w0_addr=raddr[k] → w0_data
  4. otherwise gpr[raddr[k]]
- Scoreboard next-state per register r≠0, highest priority first:
  1. flush → 0
  2. iss_en and iss_addr=r → 1 (a new producer overrides a same-cycle write clear)
  3. (w0_en and w0_addr=r) or (w1_en and w1_addr=r) → 0
  4. otherwise hold
- Issue to address 0 has no effect.
- rbusy[k] = busy[raddr[k]] and not (a same-cycle write on either port to raddr[k]). Same-cycle issue does not affect rbusy.
- busy_cnt is a registered population count of busy bits, updated to match next-state. Range 0..NREG-1.
- A write to a non-busy register is legal: data is stored and busy stays 0.

## Timing
- Reset (rst=0): immediately and asynchronously, all gpr entries = 0, all busy = 0, busy_cnt = 0.
  - rdata = 0 for every address, rbusy = 0.
  - Reset asserted mid-operation discards all pending writes/issues in that cycle.
  - First state update occurs on the first rising edge after rst returns high.
- Write-to-read latency 0 via bypass. The value is visible from storage one cycle later.
- Issue-to-rbusy latency 1 cycle.
- Write-to-rbusy-clear latency 0 (bypassed).
- No handshakes. All enables are single-cycle pulses sampled on the rising edge.
- All outputs glitch-free relative to the clk rising edge except combinational rdata/rbusy paths from raddr and write ports.

## Test plan
- Reset:
  - Write x5=0x1234 and issue x7.
  - Drop rst low mid-cycle.
  - Required: rdata for x5 immediately 0, rbusy for x7 0, busy_cnt 0.
- Bypass and x0:
  - Same cycle: w0 x3=0xAAAA, w1 x4=0xBBBB, raddr0=3, raddr1=4.
  - Required: rdata0=0xAAAA, rdata1=0xBBBB that cycle and next.
  - w0 to x0 with 0xFFFF.
  - Required: reading x0 returns 0.
- Write collision:
  - w0 and w1 both write x9 (0x1111 / 0x2222).
  - Required: same-cycle read returns 0x2222, and next cycle 0x2222.
- Scoreboard:
  - Issue x10 → next cycle rbusy=1, busy_cnt=1.
  - w1 writes x10=0x55.
  - Required: rbusy=0 same cycle, rdata=0x55, busy_cnt=0 after the edge.
- Issue vs write vs flush:
  - Same cycle: issue x12 and w0 writes x12.
  - Required: busy[x12]=1 next cycle, data stored.
  - Issue x13 with flush asserted.
  - Required: all busy 0, busy_cnt=0.
- Parameters:
  - NRD=3, NREG=16, XLEN=32.
  - Randomised writes/issues against a reference model.
  - Required: zero mismatches over 10k cycles.
